// File: rtl/mem_port_arbiter.sv
// Single-transaction arbiter sharing one memory port between fetch and the LSU.
// Optional grant counters are built when MEM_ARB_PERF_EN is defined.
module mem_port_arbiter #(
  parameter int unsigned FETCH_STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        flush,
  output logic        if_valid,
  output logic [31:0] if_data,
  output logic        if_stall,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  input  logic [3:0]  ls_be,
  output logic        ls_done,
  output logic [31:0] ls_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0] perf_if_grants,
  output logic [31:0] perf_ls_grants
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LS} state_e;

  localparam logic [3:0] LIMIT = 4'(FETCH_STARVE_LIMIT);

  state_e      state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic        drop_q, drop_d;
  logic        if_valid_q, if_valid_d;
  logic        ls_done_q, ls_done_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] ls_rdata_q, ls_rdata_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        we_q, we_d;
  logic        grant_if, grant_ls;

  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    drop_d     = drop_q;
    if_valid_d = 1'b0;
    ls_done_d  = 1'b0;
    if_data_d  = if_data_q;
    ls_rdata_d = ls_rdata_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    we_d       = we_q;
    grant_if   = 1'b0;
    grant_ls   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A flush this cycle means if_addr is stale, so fetch cannot win.
        if (if_req && starve_q == LIMIT && !flush) grant_if = 1'b1;
        else if (ls_req)                           grant_ls = 1'b1;
        else if (if_req && !flush)                 grant_if = 1'b1;
        if (grant_if) begin
          state_d  = S_FETCH;
          starve_d = '0;
          addr_d   = if_addr;
          wdata_d  = '0;
          be_d     = 4'hF;
          we_d     = 1'b0;
        end
        if (grant_ls) begin
          state_d = S_LS;
          addr_d  = ls_addr;
          wdata_d = ls_wdata;
          be_d    = ls_be;
          we_d    = ls_we;
          if (if_req && starve_q != LIMIT) starve_d = starve_q + 4'd1;
        end
      end
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_IDLE;
          drop_d  = 1'b0;
          if (!(drop_q || flush)) begin
            if_valid_d = 1'b1;
            if_data_d  = mem_rdata;
          end
        end else if (flush) begin
          drop_d = 1'b1;
        end
      end
      S_LS: begin
        if (mem_ready) begin
          state_d    = S_IDLE;
          ls_done_d  = 1'b1;
          ls_rdata_d = mem_rdata;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      starve_q   <= '0;
      drop_q     <= 1'b0;
      if_valid_q <= 1'b0;
      ls_done_q  <= 1'b0;
      if_data_q  <= '0;
      ls_rdata_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      we_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      drop_q     <= drop_d;
      if_valid_q <= if_valid_d;
      ls_done_q  <= ls_done_d;
      if_data_q  <= if_data_d;
      ls_rdata_q <= ls_rdata_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      we_q       <= we_d;
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_if_q, perf_ls_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_if_q <= '0;
      perf_ls_q <= '0;
    end else begin
      if (grant_if) perf_if_q <= perf_if_q + 32'd1;
      if (grant_ls) perf_ls_q <= perf_ls_q + 32'd1;
    end
  end

  assign perf_if_grants = perf_if_q;
  assign perf_ls_grants = perf_ls_q;
`endif

  assign mem_req   = (state_q != S_IDLE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;
  assign mem_we    = we_q;
  assign if_valid  = if_valid_q;
  assign if_data   = if_data_q;
  assign if_stall  = !if_valid_q;
  assign ls_done   = ls_done_q;
  assign ls_rdata  = ls_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;
  localparam int LIM = 4;

  logic        clock = 1'b0;
  logic        reset, if_req, flush, ls_req, ls_we, mem_ready;
  logic [31:0] if_addr, ls_addr, ls_wdata, mem_rdata;
  logic [3:0]  ls_be;
  logic        if_valid, if_stall, ls_done, mem_req, mem_we;
  logic [31:0] if_data, ls_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_if_grants, perf_ls_grants;
`endif

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.FETCH_STARVE_LIMIT(LIM)) dut (
    .clock(clock), .reset(reset), .if_req(if_req), .if_addr(if_addr), .flush(flush),
    .if_valid(if_valid), .if_data(if_data), .if_stall(if_stall),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_be(ls_be),
    .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
`ifdef MEM_ARB_PERF_EN
    , .perf_if_grants(perf_if_grants), .perf_ls_grants(perf_ls_grants)
`endif
  );

  always #5 clock = ~clock;

  // Transaction-level reference: which requester owns the port, what it asked for,
  // and the last response delivered to each side.
  typedef enum int {NONE, FETCH_T, LOAD_STORE_T} owner_t;
  owner_t      m_owner;
  logic [31:0] m_addr, m_wdata, m_ifd, m_lsr, m_pif, m_pls;
  logic [3:0]  m_be;
  logic        m_we, m_ifv, m_lsd, m_discard;
  int          m_waiting_lsu_wins;

  task automatic model_step();
    bit fetch_wins;
    if (reset) begin
      m_owner = NONE; m_addr = 0; m_wdata = 0; m_be = 0; m_we = 0;
      m_ifv = 0; m_lsd = 0; m_ifd = 0; m_lsr = 0; m_discard = 0;
      m_waiting_lsu_wins = 0; m_pif = 0; m_pls = 0;
      return;
    end
    m_ifv = 0; m_lsd = 0;
    if (m_owner == NONE) begin
      fetch_wins = if_req && !flush && (m_waiting_lsu_wins >= LIM || !ls_req);
      if (fetch_wins) begin
        m_owner = FETCH_T; m_addr = if_addr; m_be = 4'hF; m_we = 0; m_wdata = 0;
        m_waiting_lsu_wins = 0; m_pif = m_pif + 1;
      end else if (ls_req) begin
        m_owner = LOAD_STORE_T; m_addr = ls_addr; m_wdata = ls_wdata; m_be = ls_be; m_we = ls_we;
        if (if_req) m_waiting_lsu_wins = (m_waiting_lsu_wins + 1 > LIM) ? LIM : m_waiting_lsu_wins + 1;
        m_pls = m_pls + 1;
      end
    end else if (m_owner == FETCH_T) begin
      m_discard = m_discard || flush;
      if (mem_ready) begin
        if (!m_discard) begin m_ifv = 1; m_ifd = mem_rdata; end
        m_discard = 0;
        m_owner = NONE;
      end
    end else if (mem_ready) begin
      m_lsd = 1; m_lsr = mem_rdata; m_owner = NONE;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 0; ls_req = 0; flush = 0; ls_we = 0; mem_ready = 0;
    if_addr = 0; ls_addr = 0; ls_wdata = 0; ls_be = 0; mem_rdata = 0;
  endtask

  task automatic test_reset();
    idle_inputs(); reset = 1;
    tick(); tick();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b exp 0", mem_req); end
    checks++; if (if_valid !== 1'b0 || ls_done !== 1'b0) begin errors++; $display("FAIL reset_pulses: got %b%b exp 00", if_valid, ls_done); end
    checks++; if (if_stall !== 1'b1) begin errors++; $display("FAIL reset_stall: got %b exp 1", if_stall); end
    checks++; if ({if_data, ls_rdata} !== 64'h0) begin errors++; $display("FAIL reset_data: got %h %h exp 0", if_data, ls_rdata); end
    checks++; if ({mem_addr, mem_wdata, mem_be, mem_we} !== 69'h0) begin errors++; $display("FAIL reset_bus: got %h %h %h %b exp 0", mem_addr, mem_wdata, mem_be, mem_we); end
    reset = 0;
  endtask

  task automatic test_fetch_basic();
    if_req = 1; if_addr = 32'h0100_0000; mem_ready = 1; mem_rdata = 32'h0000_0013;
    tick();
    if_req = 0;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0100_0000) begin errors++; $display("FAIL fetch_c1_bus: got %b %h exp 1 01000000", mem_req, mem_addr); end
    checks++; if (mem_be !== 4'hF || mem_we !== 1'b0) begin errors++; $display("FAIL fetch_c1_be: got %h %b exp f 0", mem_be, mem_we); end
    checks++; if (if_stall !== 1'b1) begin errors++; $display("FAIL fetch_c1_stall: got %b exp 1", if_stall); end
    tick();
    checks++; if (if_valid !== 1'b1 || if_data !== 32'h13 || if_stall !== 1'b0) begin errors++; $display("FAIL fetch_c2_resp: got %b %h %b exp 1 13 0", if_valid, if_data, if_stall); end
    tick();
    checks++; if (if_valid !== 1'b0 || if_stall !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL fetch_c3: got %b %b %b exp 0 1 0", if_valid, if_stall, mem_req); end
    idle_inputs();
  endtask

  task automatic test_starvation();
    logic [31:0] exp_addr;
    reset = 1; tick(); reset = 0;
    if_req = 1; if_addr = 32'h100; ls_req = 1; ls_we = 0; ls_addr = 32'h2000; ls_be = 4'hF;
    mem_ready = 1; mem_rdata = 32'h5555_AAAA;
    for (int g = 0; g < 10; g++) begin
      tick();
      exp_addr = (g % (LIM + 1) == LIM) ? 32'h100 : 32'h2000;
      checks++; if (mem_req !== 1'b1 || mem_addr !== exp_addr) begin errors++; $display("FAIL starve_grant%0d: got %b %h exp 1 %h", g, mem_req, mem_addr, exp_addr); end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_store_wait();
    reset = 1; tick(); reset = 0;
    ls_req = 1; ls_we = 1; ls_addr = 32'h3000; ls_wdata = 32'hDEAD_BEEF; ls_be = 4'b0011; mem_rdata = 32'h0BAD_F00D;
    tick();
    ls_req = 0; ls_wdata = 0; ls_be = 0; ls_addr = 0;
    for (int c = 1; c <= 4; c++) begin
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h3000 || mem_wdata !== 32'hDEAD_BEEF || mem_be !== 4'b0011 || mem_we !== 1'b1)
        begin errors++; $display("FAIL store_hold_c%0d: got %b %h %h %h %b", c, mem_req, mem_addr, mem_wdata, mem_be, mem_we); end
      checks++; if (ls_done !== 1'b0) begin errors++; $display("FAIL store_early_done_c%0d: got %b exp 0", c, ls_done); end
      mem_ready = (c == 4);
      tick();
    end
    checks++; if (ls_done !== 1'b1 || ls_rdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL store_done_c5: got %b %h exp 1 0badf00d", ls_done, ls_rdata); end
    idle_inputs();
    tick();
    checks++; if (ls_done !== 1'b0) begin errors++; $display("FAIL store_done_pulse: got %b exp 0", ls_done); end
  endtask

  task automatic test_flush_drop();
    reset = 1; tick(); reset = 0;
    if_req = 1; if_addr = 32'h400; mem_ready = 1; mem_rdata = 32'h1111_1111;
    tick(); if_req = 0; tick();
    if_req = 1; if_addr = 32'h404; mem_ready = 0;
    tick();
    flush = 1; mem_ready = 1; mem_rdata = 32'h2222_2222;
    tick();
    checks++; if (if_valid !== 1'b0 || if_data !== 32'h1111_1111) begin errors++; $display("FAIL flush_drop: got %b %h exp 0 11111111", if_valid, if_data); end
    flush = 0; if_addr = 32'h800; mem_rdata = 32'h3333_3333;
    tick();
    if_req = 0;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h800) begin errors++; $display("FAIL flush_refetch_addr: got %b %h exp 1 800", mem_req, mem_addr); end
    tick();
    checks++; if (if_valid !== 1'b1 || if_data !== 32'h3333_3333) begin errors++; $display("FAIL flush_refetch_resp: got %b %h exp 1 33333333", if_valid, if_data); end
    // A flush in IDLE blocks fetch but still lets a waiting LSU request through.
    if_req = 1; flush = 1; ls_req = 1; ls_addr = 32'h9000; ls_we = 0; ls_be = 4'hF; mem_ready = 0;
    tick();
    checks++; if (mem_addr !== 32'h9000) begin errors++; $display("FAIL flush_idle_ls: got %h exp 9000", mem_addr); end
    idle_inputs();
    mem_ready = 1; tick(); mem_ready = 0; tick();
  endtask

  task automatic test_reset_midflight();
    reset = 1; tick(); reset = 0;
    ls_req = 1; ls_we = 0; ls_addr = 32'h7000; ls_be = 4'hF; mem_ready = 0;
    tick(); ls_req = 0; tick();
    reset = 1;
    tick();
    checks++; if (mem_req !== 1'b0 || ls_done !== 1'b0) begin errors++; $display("FAIL midreset_req: got %b %b exp 0 0", mem_req, ls_done); end
    checks++; if (mem_addr !== 32'h0 || mem_be !== 4'h0 || if_stall !== 1'b1) begin errors++; $display("FAIL midreset_vals: got %h %h %b exp 0 0 1", mem_addr, mem_be, if_stall); end
    reset = 0; mem_ready = 1;
    tick();
    checks++; if (mem_req !== 1'b0 || ls_done !== 1'b0) begin errors++; $display("FAIL midreset_after: got %b %b exp 0 0", mem_req, ls_done); end
    idle_inputs();
  endtask

`ifdef MEM_ARB_PERF_EN
  task automatic test_perf();
    reset = 1; tick(); reset = 0;
    if_req = 1; if_addr = 32'h40; mem_ready = 1;
    for (int i = 0; i < 6; i++) tick();
    if_req = 0; ls_req = 1; ls_addr = 32'h80;
    for (int i = 0; i < 4; i++) tick();
    ls_req = 0; tick();
    checks++; if (perf_if_grants !== 32'd3 || perf_ls_grants !== 32'd2) begin errors++; $display("FAIL perf_counts: got %0d %0d exp 3 2", perf_if_grants, perf_ls_grants); end
    idle_inputs();
  endtask
`endif

  task automatic test_random();
    reset = 1; tick(); reset = 0;
    for (int n = 0; n < 1500; n++) begin
      reset     = ($urandom_range(0, 199) == 0);
      if_req    = ($urandom_range(0, 3) != 0);
      ls_req    = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 7) == 0);
      ls_we     = 1'($urandom_range(0, 1));
      if_addr   = $urandom;
      ls_addr   = $urandom;
      ls_wdata  = $urandom;
      ls_be     = 4'($urandom_range(0, 15));
      mem_ready = ($urandom_range(0, 2) != 0);
      mem_rdata = $urandom;
      tick();
      checks++; if (mem_req !== (m_owner != NONE)) begin errors++; $display("FAIL rnd_mem_req@%0d: got %b exp %b", n, mem_req, m_owner != NONE); end
      if (m_owner != NONE) begin
        checks++; if (mem_addr !== m_addr || mem_be !== m_be || mem_we !== m_we) begin errors++; $display("FAIL rnd_bus@%0d: got %h %h %b exp %h %h %b", n, mem_addr, mem_be, mem_we, m_addr, m_be, m_we); end
      end
      if (m_owner == LOAD_STORE_T) begin
        checks++; if (mem_wdata !== m_wdata) begin errors++; $display("FAIL rnd_wdata@%0d: got %h exp %h", n, mem_wdata, m_wdata); end
      end
      checks++; if (if_valid !== m_ifv || if_stall !== !m_ifv || if_data !== m_ifd) begin errors++; $display("FAIL rnd_if@%0d: got %b %b %h exp %b %b %h", n, if_valid, if_stall, if_data, m_ifv, !m_ifv, m_ifd); end
      checks++; if (ls_done !== m_lsd || ls_rdata !== m_lsr) begin errors++; $display("FAIL rnd_ls@%0d: got %b %h exp %b %h", n, ls_done, ls_rdata, m_lsd, m_lsr); end
`ifdef MEM_ARB_PERF_EN
      checks++; if (perf_if_grants !== m_pif || perf_ls_grants !== m_pls) begin errors++; $display("FAIL rnd_perf@%0d: got %0d %0d exp %0d %0d", n, perf_if_grants, perf_ls_grants, m_pif, m_pls); end
`endif
    end
    reset = 0;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    test_reset();
    test_fetch_basic();
    test_starvation();
    test_store_wait();
    test_flush_drop();
    test_reset_midflight();
`ifdef MEM_ARB_PERF_EN
    test_perf();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
